mul_pipe: RTL and testbench

MUL_PIPE -- requirements
Module: mul_pipe

---
 rtl/mul_pipe_pkg.sv | 16 +
 rtl/mul_etm_core.sv | 44 ++++
 rtl/mul_pipe.sv | 98 +++++++++
 tb/tb_mul_pipe.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// Shared types and width helpers for the mul_pipe multiply-accumulate pipeline.
// Signedness mode encodes bit1 = x signed, bit0 = y signed.
package mul_pipe_pkg;

  typedef enum logic [1:0] {
    UU = 2'b00,
    US = 2'b01,
    SU = 2'b10,
    SS = 2'b11
  } sign_mode_e;

  function automatic int acc_width(input int n, input int guard);
    return 2 * n + guard;
  endfunction

endpackage

// File: rtl/mul_etm_core.sv
// Combinational 2N-bit multiplier with per-operand signedness and ETM approximation.
// Zero latency; no flow control (pure function of its inputs).
module mul_etm_core
  import mul_pipe_pkg::*;
#(
  parameter int N        = 16,
  parameter int APPROX_K = 4
) (
  input  logic [N-1:0]   x_i,
  input  logic [N-1:0]   y_i,
  input  logic [1:0]     s_i,
  input  logic           approx_i,
  output logic [2*N-1:0] p_o
);

  localparam int H = N - APPROX_K;

  logic [2*N-1:0] x_ext;
  logic [2*N-1:0] y_ext;
  logic [2*N-1:0] exact_prod;
  logic [2*H-1:0] x_hi;
  logic [2*H-1:0] y_hi;
  logic [2*H-1:0] hi_prod;
  logic           hi_nz;
  logic           use_approx;

  // Extending each operand to 2N bits makes the low 2N bits of the product
  // correct for every signedness mix, since the true product always fits.
  always_comb begin
    x_ext      = {{N{s_i[1] & x_i[N-1]}}, x_i};
    y_ext      = {{N{s_i[0] & y_i[N-1]}}, y_i};
    exact_prod = x_ext * y_ext;

    x_hi       = {{H{1'b0}}, x_i[N-1:APPROX_K]};
    y_hi       = {{H{1'b0}}, y_i[N-1:APPROX_K]};
    hi_prod    = x_hi * y_hi;

    hi_nz      = (|x_i[N-1:APPROX_K]) | (|y_i[N-1:APPROX_K]);
    use_approx = approx_i && (sign_mode_e'(s_i) == UU) && hi_nz;

    p_o = use_approx ? {hi_prod, {(2*APPROX_K){1'b1}}} : exact_prod;
  end

endmodule

// File: rtl/mul_pipe.sv
// Two-stage multiply-accumulate pipe: S1 holds the product, S2 the running sum; 2-cycle latency.
// Backpressure: in_ready_o = !out_valid_o | out_ready_i; both stages freeze when it is low.
module mul_pipe
  import mul_pipe_pkg::*;
#(
  parameter int N         = 16,
  parameter int APPROX_K  = 4,
  parameter int ACC_GUARD = 8,
  localparam int ACC_W    = acc_width(N, ACC_GUARD)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [N-1:0]     x_i,
  input  logic [N-1:0]     y_i,
  input  logic [1:0]       s_i,
  input  logic             approx_i,
  input  logic             acc_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] p_o
);

  logic [2*N-1:0]   prod;
  logic             advance;

  logic             s1_vld_q,  s1_vld_d;
  logic [2*N-1:0]   s1_prod_q, s1_prod_d;
  logic             s1_sext_q, s1_sext_d;
  logic             s1_acc_q,  s1_acc_d;

  logic             s2_vld_q,  s2_vld_d;
  logic [ACC_W-1:0] s2_q,      s2_d;
  logic [ACC_W-1:0] prod_ext;

  mul_etm_core #(
    .N        (N),
    .APPROX_K (APPROX_K)
  ) u_core (
    .x_i      (x_i),
    .y_i      (y_i),
    .s_i      (s_i),
    .approx_i (approx_i),
    .p_o      (prod)
  );

  assign advance     = !s2_vld_q || out_ready_i;
  assign in_ready_o  = advance;
  assign out_valid_o = s2_vld_q;
  assign p_o         = s2_q;

  // S2 keeps its sum across bubbles so the next acc beat adds onto the
  // last transferred result, never onto a value it already added.
  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_prod_d = s1_prod_q;
    s1_sext_d = s1_sext_q;
    s1_acc_d  = s1_acc_q;
    s2_vld_d  = s2_vld_q;
    s2_d      = s2_q;

    prod_ext = s1_sext_q ? {{ACC_GUARD{s1_prod_q[2*N-1]}}, s1_prod_q}
                         : {{ACC_GUARD{1'b0}}, s1_prod_q};

    if (advance) begin
      s1_vld_d = in_valid_i;
      if (in_valid_i) begin
        s1_prod_d = prod;
        s1_sext_d = (sign_mode_e'(s_i) != UU);
        s1_acc_d  = acc_i;
      end
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_d = s1_acc_q ? (s2_q + prod_ext) : prod_ext;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q  <= 1'b0;
      s1_prod_q <= '0;
      s1_sext_q <= 1'b0;
      s1_acc_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_q      <= '0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_prod_q <= s1_prod_d;
      s1_sext_q <= s1_sext_d;
      s1_acc_q  <= s1_acc_d;
      s2_vld_q  <= s2_vld_d;
      s2_q      <= s2_d;
    end
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Bench for mul_pipe at N=8, APPROX_K=4, ACC_GUARD=8: directed cases plus a randomized stream.
module tb_mul_pipe;

  localparam int N  = 8;
  localparam int K  = 4;
  localparam int G  = 8;
  localparam int AW = 2 * N + G;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  x;
  logic [N-1:0]  y;
  logic [1:0]    s;
  logic          approx;
  logic          acc;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] p;

  int compared   = 0;
  int mismatched = 0;

  logic [AW-1:0] got_q[$];
  logic [AW-1:0] exp_q[$];

  mul_pipe #(
    .N         (N),
    .APPROX_K  (K),
    .ACC_GUARD (G)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .x_i         (x),
    .y_i         (y),
    .s_i         (s),
    .approx_i    (approx),
    .acc_i       (acc),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .p_o         (p)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got_q.push_back(p);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference product straight from the arithmetic rules, wrapped to AW bits.
  function automatic logic [AW-1:0] ref_prod(input logic [N-1:0] xv, input logic [N-1:0] yv,
                                             input logic [1:0] sv, input logic av);
    longint xs, ys, xh, yh, pr;
    logic [63:0] pr_bits;
    xs = longint'(xv);
    ys = longint'(yv);
    if (sv[1] && xv[N-1]) xs = xs - (longint'(1) << N);
    if (sv[0] && yv[N-1]) ys = ys - (longint'(1) << N);
    xh = longint'(xv) >> K;
    yh = longint'(yv) >> K;
    if (av && sv == 2'b00 && (xh != 0 || yh != 0))
      pr = (xh * yh) * (longint'(1) << (2 * K)) + ((longint'(1) << (2 * K)) - 1);
    else
      pr = xs * ys;
    pr_bits = pr;
    return pr_bits[AW-1:0];
  endfunction

  task automatic send(input logic [N-1:0] xv, input logic [N-1:0] yv, input logic [1:0] sv,
                      input logic av, input logic accv);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    x        = xv;
    y        = yv;
    s        = sv;
    approx   = av;
    acc      = accv;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int c;
    c = 0;
    while (got_q.size() < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    x         = '0;
    y         = '0;
    s         = 2'b00;
    approx    = 1'b0;
    acc       = 1'b0;
    out_ready = 1'b1;
    #7;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    compared++;
    if (p !== 24'h000000) begin
      mismatched++;
      $display("FAIL reset_p: got %h want 000000", p);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency();
    got_q.delete();
    send(8'hFF, 8'hFF, 2'b00, 1'b0, 1'b0);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL latency_early: out_valid got %b want 0 one cycle after capture", out_valid);
    end
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b1 || p !== 24'h00FE01) begin
      mismatched++;
      $display("FAIL latency_unsigned: got valid=%b p=%h want valid=1 p=00fe01", out_valid, p);
    end
    wait_outputs(1);
  endtask

  task automatic test_signed();
    got_q.delete();
    send(8'h80, 8'h80, 2'b11, 1'b0, 1'b0);
    send(8'hFF, 8'hFF, 2'b10, 1'b0, 1'b0);
    wait_outputs(2);
    compared++;
    if (got_q.size() != 2) begin
      mismatched++;
      $display("FAIL signed_count: got %0d want 2", got_q.size());
    end
    compared++;
    if (got_q[0] !== 24'h004000) begin
      mismatched++;
      $display("FAIL signed_ss: got %h want 004000", got_q[0]);
    end
    compared++;
    if (got_q[1] !== 24'hFFFF01) begin
      mismatched++;
      $display("FAIL signed_su: got %h want ffff01", got_q[1]);
    end
  endtask

  task automatic test_etm();
    got_q.delete();
    send(8'h0F, 8'h0C, 2'b00, 1'b1, 1'b0);
    send(8'h35, 8'h42, 2'b00, 1'b1, 1'b0);
    send(8'h35, 8'h42, 2'b11, 1'b1, 1'b0);
    wait_outputs(3);
    compared++;
    if (got_q.size() != 3) begin
      mismatched++;
      $display("FAIL etm_count: got %0d want 3", got_q.size());
    end
    compared++;
    if (got_q[0] !== 24'h0000B4) begin
      mismatched++;
      $display("FAIL etm_low_exact: got %h want 0000b4", got_q[0]);
    end
    compared++;
    if (got_q[1] !== 24'h000CFF) begin
      mismatched++;
      $display("FAIL etm_approx: got %h want 000cff", got_q[1]);
    end
    compared++;
    if (got_q[2] !== 24'h000DAA) begin
      mismatched++;
      $display("FAIL etm_signed_ignored: got %h want 000daa", got_q[2]);
    end
  endtask

  task automatic test_accumulate();
    logic [AW-1:0] want[4];
    want = '{24'd100, 24'd200, 24'd300, 24'd100};
    got_q.delete();
    send(8'd10, 8'd10, 2'b00, 1'b0, 1'b0);
    send(8'd10, 8'd10, 2'b00, 1'b0, 1'b1);
    send(8'd10, 8'd10, 2'b00, 1'b0, 1'b1);
    send(8'd10, 8'd10, 2'b00, 1'b0, 1'b0);
    wait_outputs(4);
    compared++;
    if (got_q.size() != 4) begin
      mismatched++;
      $display("FAIL acc_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (got_q[i] !== want[i]) begin
        mismatched++;
        $display("FAIL acc_beat%0d: got %0d want %0d", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    got_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(8'(i + 2), 8'd3, 2'b00, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(negedge clk);
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          mismatched++;
          $display("FAIL bp_stall: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid);
        end
        compared++;
        if (p !== 24'd6) begin
          mismatched++;
          $display("FAIL bp_hold_a: got %0d want 6", p);
        end
        @(negedge clk);
        compared++;
        if (p !== 24'd6 || in_ready !== 1'b0) begin
          mismatched++;
          $display("FAIL bp_hold_b: got p=%0d in_ready=%b want 6/0", p, in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_outputs(4);
    compared++;
    if (got_q.size() != 4) begin
      mismatched++;
      $display("FAIL bp_count: got %0d want 4", got_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (got_q[i] !== 24'(3 * (i + 2))) begin
        mismatched++;
        $display("FAIL bp_beat%0d: got %0d want %0d", i, got_q[i], 3 * (i + 2));
      end
    end
  endtask

  task automatic test_reset_midstream();
    got_q.delete();
    out_ready = 1'b1;
    send(8'd5, 8'd5, 2'b00, 1'b0, 1'b0);
    send(8'd7, 8'd7, 2'b00, 1'b0, 1'b1);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_inflight: out_valid got %b want 1", out_valid);
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || p !== 24'd0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rst_mid_clear: got valid=%b p=%h rdy=%b want 0/000000/1", out_valid, p, in_ready);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid_discard: out_valid got %b want 0", out_valid);
    end
    got_q.delete();
    send(8'd3, 8'd3, 2'b00, 1'b0, 1'b1);
    wait_outputs(1);
    compared++;
    if (got_q.size() != 1 || got_q[0] !== 24'd9) begin
      mismatched++;
      $display("FAIL rst_mid_acc: got n=%0d p=%0d want n=1 p=9", got_q.size(), got_q[0]);
    end
  endtask

  task automatic test_random();
    logic          done;
    logic [AW-1:0] model_acc;
    logic [N-1:0]  xv, yv;
    logic [1:0]    sv;
    logic          av, accv;
    localparam int BEATS = 150;
    done      = 1'b0;
    model_acc = '0;
    got_q.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < BEATS; i++) begin
          xv   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
          yv   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
          sv   = 2'($urandom);
          av   = 1'($urandom);
          accv = (i == 0) ? 1'b0 : 1'($urandom);
          model_acc = accv ? model_acc + ref_prod(xv, yv, sv, av) : ref_prod(xv, yv, sv, av);
          exp_q.push_back(model_acc);
          send(xv, yv, sv, av, accv);
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(BEATS);
    compared++;
    if (got_q.size() != BEATS) begin
      mismatched++;
      $display("FAIL rand_count: got %0d want %0d", got_q.size(), BEATS);
    end
    for (int i = 0; i < BEATS; i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin
        mismatched++;
        $display("FAIL rand_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_signed();
    test_etm();
    test_accumulate();
    test_backpressure();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
